// File: rtl/ttl_lookahead_accumulator.sv
// ttl_lookahead_accumulator
// Registered add/subtract accumulator built from 4-bit slices. Each slice
// exports active-low group generate/propagate to an external carry-lookahead
// generator and takes its slice carry-in back from it. Slice 0 uses the
// local effective carry-in, which is also exported as cn_out_o.
// Output rise/fall delays are a simulation artefact and are not modelled here.
module ttl_lookahead_accumulator #(
    parameter int GROUPS = 4
) (
    input  logic                  clk_i,
    input  logic                  clear_bar_i,
    input  logic [1:0]            op_i,
    input  logic [4*GROUPS-1:0]   b_i,
    input  logic                  cn_i,
    input  logic [GROUPS-2:0]     cn_group_i,
    output logic                  cn_out_o,
    output logic [GROUPS-1:0]     g_bar_o,
    output logic [GROUPS-1:0]     p_bar_o,
    output logic [4*GROUPS-1:0]   acc_o,
    output logic                  cout_o,
    output logic                  zero_o
);

    localparam int WIDTH = 4 * GROUPS;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              cout_q, cout_d;
    logic              zero_q, zero_d;

    logic [WIDTH-1:0]  bx;
    logic [WIDTH-1:0]  bit_g;
    logic [WIDTH-1:0]  bit_p;
    logic [GROUPS-1:0] grp_g;
    logic [GROUPS-1:0] grp_p;
    logic [GROUPS-1:0] c_in;
    logic [WIDTH-1:0]  sum;
    logic              cout_top;

    // Operand conditioning: subtract is add of the complement with carry-in forced high.
    always_comb begin
        bx       = (op_i == OP_SUB) ? ~b_i : b_i;
        cn_out_o = 1'b0;
        if (op_i == OP_SUB) begin
            cn_out_o = 1'b1;
        end else if (op_i == OP_ADD) begin
            cn_out_o = cn_i;
        end
    end

    // Bit and group generate/propagate; these depend only on acc, b and op.
    always_comb begin
        bit_g = acc_q & bx;
        bit_p = acc_q | bx;
        grp_g = '0;
        grp_p = '0;
        for (int i = 0; i < GROUPS; i++) begin
            grp_g[i] = bit_g[4*i+3]
                     | (bit_p[4*i+3] & bit_g[4*i+2])
                     | (bit_p[4*i+3] & bit_p[4*i+2] & bit_g[4*i+1])
                     | (bit_p[4*i+3] & bit_p[4*i+2] & bit_p[4*i+1] & bit_g[4*i]);
            grp_p[i] = bit_p[4*i+3] & bit_p[4*i+2] & bit_p[4*i+1] & bit_p[4*i];
        end
    end

    assign g_bar_o = ~grp_g;
    assign p_bar_o = ~grp_p;

    // Slice carry-ins: slice 0 is local, the rest come from the external lookahead unit.
    always_comb begin
        c_in[0] = cn_out_o;
        for (int i = 1; i < GROUPS; i++) begin
            c_in[i] = cn_group_i[i-1];
        end
    end

    // Ripple inside each slice from its carry-in; external carries are trusted as supplied.
    always_comb begin
        logic c;
        sum = '0;
        c   = 1'b0;
        for (int i = 0; i < GROUPS; i++) begin
            c = c_in[i];
            for (int k = 0; k < 4; k++) begin
                sum[4*i+k] = acc_q[4*i+k] ^ bx[4*i+k] ^ c;
                c          = bit_g[4*i+k] | (bit_p[4*i+k] & c);
            end
        end
        cout_top = grp_g[GROUPS-1] | (grp_p[GROUPS-1] & c_in[GROUPS-1]);
    end

    // Next-state selection by operation; zero flag tracks the value being written.
    always_comb begin
        acc_d  = acc_q;
        cout_d = cout_q;
        case (op_i)
            OP_HOLD: begin
                acc_d  = acc_q;
                cout_d = cout_q;
            end
            OP_LOAD: begin
                acc_d  = b_i;
                cout_d = 1'b0;
            end
            default: begin
                acc_d  = sum;
                cout_d = cout_top;
            end
        endcase
        zero_d = (acc_d == '0);
    end

    // State registers with synchronous active-low clear taking priority over any op.
    always_ff @(posedge clk_i) begin
        if (!clear_bar_i) begin
            acc_q  <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            acc_q  <= acc_d;
            cout_q <= cout_d;
            zero_q <= zero_d;
        end
    end

    assign acc_o  = acc_q;
    assign cout_o = cout_q;
    assign zero_o = zero_q;

endmodule

// File: tb/tb_ttl_lookahead_accumulator.sv
// Directed bench for ttl_lookahead_accumulator with a behavioural
// carry-lookahead generator closing the G/P -> carry loop.
module tb_ttl_lookahead_accumulator;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    logic        clk;
    logic        clear_bar;
    logic [1:0]  op;
    logic [15:0] b;
    logic        cn;
    logic [2:0]  cn_group;
    logic        cn_out;
    logic [3:0]  g_bar;
    logic [3:0]  p_bar;
    logic [15:0] acc;
    logic        cout;
    logic        zero;

    int n_checks = 0;
    int n_fail   = 0;

    ttl_lookahead_accumulator #(.GROUPS(4)) dut (
        .clk_i       (clk),
        .clear_bar_i (clear_bar),
        .op_i        (op),
        .b_i         (b),
        .cn_i        (cn),
        .cn_group_i  (cn_group),
        .cn_out_o    (cn_out),
        .g_bar_o     (g_bar),
        .p_bar_o     (p_bar),
        .acc_o       (acc),
        .cout_o      (cout),
        .zero_o      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural lookahead carry generator (Cnx, Cny, Cnz).
    always_comb begin
        logic [3:0] gg, pp;
        gg = ~g_bar;
        pp = ~p_bar;
        cn_group[0] = gg[0] | (pp[0] & cn_out);
        cn_group[1] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cn_out);
        cn_group[2] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                    | (pp[2] & pp[1] & pp[0] & cn_out);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic clr_b, input logic [1:0] o, input logic [15:0] bv, input logic c);
        clear_bar = clr_b;
        op        = o;
        b         = bv;
        cn        = c;
        #1;
    endtask

    initial begin
        clear_bar = 1'b0;
        op        = OP_ADD;
        b         = 16'hFFFF;
        cn        = 1'b0;
        #2;

        // Reset
        tick();
        check_val("rst_acc",  acc,  16'h0000);
        check_val("rst_cout", cout, 1'b0);
        check_val("rst_zero", zero, 1'b1);
        check_val("rst_gbar", g_bar, 4'b1111);
        check_val("rst_pbar", p_bar, 4'b0000);

        // Load then hold with B toggling
        drive(1'b1, OP_LOAD, 16'h1234, 1'b0);
        tick();
        check_val("load_acc",  acc,  16'h1234);
        check_val("load_cout", cout, 1'b0);
        check_val("load_zero", zero, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, OP_HOLD, (i[0] ? 16'hAAAA : 16'h5555), 1'b1);
            tick();
            check_val("hold_acc", acc, 16'h1234);
        end

        // Full ripple through all slices
        drive(1'b1, OP_LOAD, 16'hFFFF, 1'b0);
        tick();
        drive(1'b1, OP_ADD, 16'h0001, 1'b0);
        check_val("rip_gbar",  g_bar,    4'b1110);
        check_val("rip_pbar",  p_bar,    4'b0000);
        check_val("rip_cng",   cn_group, 3'b111);
        check_val("rip_cnout", cn_out,   1'b0);
        tick();
        check_val("rip_acc",  acc,  16'h0000);
        check_val("rip_cout", cout, 1'b1);
        check_val("rip_zero", zero, 1'b1);
        drive(1'b1, OP_HOLD, 16'h0F0F, 1'b0);
        tick();
        check_val("hold_cout", cout, 1'b1);
        check_val("hold_zero", zero, 1'b1);

        // Subtract with borrow, then without
        drive(1'b1, OP_LOAD, 16'h0005, 1'b0);
        tick();
        drive(1'b1, OP_SUB, 16'h0007, 1'b0);
        check_val("sub1_cnout", cn_out, 1'b1);
        tick();
        check_val("sub1_acc",  acc,  16'hFFFE);
        check_val("sub1_cout", cout, 1'b0);
        check_val("sub1_zero", zero, 1'b0);
        drive(1'b1, OP_LOAD, 16'h0007, 1'b0);
        tick();
        drive(1'b1, OP_SUB, 16'h0005, 1'b0);
        tick();
        check_val("sub2_acc",  acc,  16'h0002);
        check_val("sub2_cout", cout, 1'b1);

        // Clear mid-operation wins over ADD
        drive(1'b1, OP_LOAD, 16'h00FF, 1'b0);
        tick();
        drive(1'b0, OP_ADD, 16'h0101, 1'b0);
        tick();
        check_val("clr_acc",  acc,  16'h0000);
        check_val("clr_cout", cout, 1'b0);
        check_val("clr_zero", zero, 1'b1);
        drive(1'b1, OP_ADD, 16'h0101, 1'b0);
        tick();
        check_val("clr_next_acc", acc, 16'h0101);

        // Carry-in honoured for ADD, forced low for LOAD
        drive(1'b1, OP_LOAD, 16'h0FFF, 1'b0);
        tick();
        drive(1'b1, OP_ADD, 16'h0000, 1'b1);
        check_val("cin_cnout", cn_out, 1'b1);
        tick();
        check_val("cin_acc",  acc,  16'h1000);
        check_val("cin_cout", cout, 1'b0);
        drive(1'b1, OP_LOAD, 16'h0000, 1'b1);
        check_val("ld_cnout", cn_out, 1'b0);
        tick();
        check_val("ld_acc",  acc,  16'h0000);
        check_val("ld_zero", zero, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
